// File: rtl/mmio_uart_tx.sv
// Memory-mapped, FIFO-buffered 8N1 UART transmitter (TXDATA at BASE_ADDR, STATUS at BASE_ADDR+1).
// Define MMIO_UART_TX_PARITY_EN to insert one even-parity bit between data and stop.
module mmio_uart_tx #(
    parameter logic [11:0] BASE_ADDR    = 12'hFF0,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] ram_addr,
    input  logic [31:0] data_mem_in,
    input  logic        mem_wr,
    input  logic        mem_rd,
    output logic        sel_out,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        busy
);
    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam int             CW        = AW + 1;
    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [11:0]    STAT_ADDR = BASE_ADDR + 12'd1;

`ifdef MMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    state_t        r_state, w_state_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt;
`ifdef MMIO_UART_TX_PARITY_EN
    logic          r_par, w_par_nxt;
`endif

    logic w_sel_data, w_sel_stat, w_full, w_empty, w_busy;
    logic w_push_req, w_push, w_pop, w_ovf_set, w_bit_end;
    logic [7:0]  w_head;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_unused   = ^data_mem_in[31:8];
    assign w_sel_data = (ram_addr == BASE_ADDR);
    assign w_sel_stat = (ram_addr == STAT_ADDR);
    assign sel_out    = w_sel_data || w_sel_stat;

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rptr];
    assign w_busy     = (r_state != S_IDLE) || !w_empty;
    assign busy       = w_busy;
    assign tx         = r_tx;

    // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
    assign w_push_req = mem_wr && w_sel_data;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;

    assign w_status = {16'h0, 8'(r_count), 4'h0, r_ovf, w_busy, w_empty, w_full};
    assign rd_data  = (mem_rd && w_sel_stat) ? w_status : 32'h0;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= data_mem_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (mem_wr && w_sel_stat) r_ovf <= 1'b0;
            else if (w_ovf_set)       r_ovf <= 1'b1;
        end
    end

    assign w_bit_end = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + BW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                    w_shift_nxt = w_head;
`ifdef MMIO_UART_TX_PARITY_EN
                    w_par_nxt   = ^w_head;
`endif
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_baud_nxt  = '0;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit so frames carry no idle gap.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                        w_shift_nxt = w_head;
`ifdef MMIO_UART_TX_PARITY_EN
                        w_par_nxt   = ^w_head;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
            end
        endcase

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = w_par_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h0;
            r_tx    <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
`ifdef MMIO_UART_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: vector table, directed corner sequences and random traffic
// checked every cycle against a frame-timing model built on a byte queue.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [11:0] BASE  = 12'hFF0;
    localparam logic [11:0] STAT  = 12'hFF1;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] ram_addr = 12'h0;
    logic [31:0] data_mem_in = 32'h0;
    logic        mem_wr = 1'b0;
    logic        mem_rd = 1'b0;
    logic        sel_out;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;

    always #5 clk = ~clk;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ram_addr(ram_addr), .data_mem_in(data_mem_in),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .sel_out(sel_out), .rd_data(rd_data),
        .tx(tx), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    // Model: queued bytes, edge index of the latest pop, byte in flight, sticky overflow.
    logic [7:0]  q[$];
    longint      cyc = 0;
    longint      last_pop = -1000;
    logic [7:0]  cur = 8'h0;
    logic        ovf_m = 1'b0;
    logic [31:0] last_rd;
    logic        last_sel;

    function automatic logic exp_busy();
        return (q.size() != 0) || (cyc - last_pop < FRAME);
    endfunction

    function automatic logic exp_tx();
        longint d = cyc - last_pop;
        int k;
        if (d >= FRAME) return 1'b1;
        k = int'(d / CPB);
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        if (NBITS == 11 && k == 9) return ^cur;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        return {16'h0, 8'(q.size()), 4'h0, ovf_m, exp_busy(), (q.size() == 0), (q.size() == DEPTH)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: cyc=%0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic rd,
                        input logic [11:0] addr, input logic [31:0] d);
        logic pop;
        reset = rst; mem_wr = wr; mem_rd = rd; ram_addr = addr; data_mem_in = d;
        #1;
        last_rd  = rd_data;
        last_sel = sel_out;
        chk("sel_out", {31'b0, sel_out}, {31'b0, (addr == BASE || addr == STAT)});
        chk("rd_data", rd_data, (rd && addr == STAT) ? exp_status() : 32'h0);
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            last_pop = -1000;
            ovf_m = 1'b0;
        end else begin
            pop = (q.size() != 0) && (cyc >= last_pop + FRAME);
            if (pop) begin
                cur = q.pop_front();
                last_pop = cyc;
            end
            if (wr && addr == BASE) begin
                if (q.size() < DEPTH) q.push_back(d[7:0]);
                else ovf_m = 1'b1;
            end
            if (wr && addr == STAT) ovf_m = 1'b0;
        end
        #1;
        chk("tx", {31'b0, tx}, {31'b0, exp_tx()});
        chk("busy", {31'b0, busy}, {31'b0, exp_busy()});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 12'h000, 32'h0);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        step(1'b0, 1'b1, 1'b0, BASE, {24'hABCD00, b});
    endtask

    task automatic rd_stat();
        step(1'b0, 1'b0, 1'b1, STAT, 32'h0);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && busy; i++) idle();
        chk("drain_timeout", {31'b0, busy}, 32'h0);
    endtask

    typedef struct {
        logic        rd;
        logic [11:0] addr;
        logic        exp_sel;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        int   exp_bits[NBITS];
        longint e0;
        int   wp;
        int   r;

        vt[0] = '{1'b1, BASE,   1'b1, 32'h0};
        vt[1] = '{1'b1, STAT,   1'b1, 32'h2};
        vt[2] = '{1'b0, STAT,   1'b1, 32'h0};
        vt[3] = '{1'b1, 12'hFEF, 1'b0, 32'h0};
        vt[4] = '{1'b1, 12'hFF2, 1'b0, 32'h0};
        vt[5] = '{1'b1, 12'h000, 1'b0, 32'h0};
        vt[6] = '{1'b0, BASE,   1'b1, 32'h0};
`ifdef MMIO_UART_TX_PARITY_EN
        exp_bits = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
        exp_bits = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif

        // Reset state
        do_reset();
        do_reset();
        chk("reset_tx", {31'b0, tx}, 32'h1);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        rd_stat();
        chk("reset_status", last_rd, 32'h0000_0002);

        // Address decode / read data table
        foreach (vt[i]) begin
            step(1'b0, 1'b0, vt[i].rd, vt[i].addr, 32'hFFFF_FFFF);
            chk("vec_sel", {31'b0, last_sel}, {31'b0, vt[i].exp_sel});
            chk("vec_rd", last_rd, vt[i].exp_rd);
        end
        step(1'b0, 1'b1, 1'b0, 12'h123, 32'h0000_00AA);
        rd_stat();
        chk("unmapped_wr", last_rd, 32'h0000_0002);

        // Single byte, mid-bit sampling
        step(1'b0, 1'b1, 1'b0, BASE, 32'hABCD_0055);
        for (int n = 1; n <= FRAME + 1; n++) begin
            idle();
            if (n == 1) chk("tx_fall", {31'b0, tx}, 32'h0);
            if ((n - 1) % CPB == 2) chk("midbit", {31'b0, tx}, exp_bits[(n-1)/CPB]);
            if (n == FRAME) chk("busy_hold", {31'b0, busy}, 32'h1);
            if (n == FRAME + 1) chk("busy_drop", {31'b0, busy}, 32'h0);
        end

        // Overflow: 6 writes into a 4-deep FIFO, one popped immediately
        do_reset();
        for (int b = 1; b <= 6; b++) wr_byte(8'(b));
        rd_stat();
        chk("ovf_set", {31'b0, last_rd[3]}, 32'h1);
        chk("ovf_count", {24'b0, last_rd[15:8]}, 32'h4);
        drain(6 * FRAME);
        step(1'b0, 1'b1, 1'b0, STAT, 32'hFFFF_FFFF);
        rd_stat();
        chk("ovf_clear", {31'b0, last_rd[3]}, 32'h0);

        // Full FIFO written on the stop->start pop edge
        do_reset();
        wr_byte(8'h11);
        e0 = cyc;
        wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44); wr_byte(8'h55);
        rd_stat();
        chk("fp_full", {31'b0, last_rd[0]}, 32'h1);
        while (cyc < e0 + FRAME) idle();
        wr_byte(8'h66);
        chk("fp_start", {31'b0, tx}, 32'h0);
        rd_stat();
        chk("fp_count", {24'b0, last_rd[15:8]}, 32'h4);
        chk("fp_no_ovf", {31'b0, last_rd[3]}, 32'h0);
        drain(6 * FRAME);

        // Reset during data bit 3 (0x35 has bit3 = 0)
        do_reset();
        wr_byte(8'h35);
        e0 = cyc;
        wr_byte(8'h5A);
        while (cyc < e0 + 1 + 4 * CPB + 1) idle();
        chk("mfr_bit3", {31'b0, tx}, 32'h0);
        do_reset();
        chk("mfr_tx", {31'b0, tx}, 32'h1);
        rd_stat();
        chk("mfr_status", last_rd, 32'h0000_0002);
        for (int i = 0; i < 2 * FRAME; i++) idle();
        chk("mfr_quiet", {31'b0, busy}, 32'h0);

`ifdef MMIO_UART_TX_PARITY_EN
        // Parity bit: 0x07 -> 1, 0x03 -> 0
        do_reset();
        wr_byte(8'h07);
        for (int n = 1; n <= FRAME + 1; n++) begin
            idle();
            if (n - 1 == 9 * CPB + 2) chk("par_07", {31'b0, tx}, 32'h1);
            if (n == FRAME) chk("par_len_hold", {31'b0, busy}, 32'h1);
            if (n == FRAME + 1) chk("par_len_drop", {31'b0, busy}, 32'h0);
        end
        wr_byte(8'h03);
        for (int n = 1; n <= FRAME + 1; n++) begin
            idle();
            if (n - 1 == 9 * CPB + 2) chk("par_03", {31'b0, tx}, 32'h0);
        end
`endif

        // Random traffic with alternating burst / sparse phases
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            wp = ((i / 200) % 2 == 1) ? 60 : 8;
            r  = int'($urandom_range(0, 99));
            if (r < wp)
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)), BASE, $urandom());
            else if (r < wp + 3)
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)), STAT, $urandom());
            else if (r < wp + 15)
                rd_stat();
            else if (r < wp + 20)
                step(1'b0, 1'b0, 1'b1, BASE, 32'h0);
            else if (r < wp + 25)
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     12'($urandom_range(0, 4095)), $urandom());
            else if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                idle();
        end
        drain(6 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
